bfm_ahbl_slave_mem: RTL and testbench

Behavioural AHB-Lite slave memory: the responder end of the AHB master/APB-bridge BFM wrapper, decoded on one HSEL bit. Holds a word-organised RAM and supports byte, halfword and word access. Inserts a run-time programmable number of wait states and returns two-cycle ERROR for illegal accesses. Used in testbenches as an AHB target and scoreboard memory.

---
 rtl/bfm_ahbl_slave_mem.sv | 135 +++++++++++++
 tb/tb_bfm_ahbl_slave_mem.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bfm_ahbl_slave_mem.sv
// bfm_ahbl_slave_mem: AHB-Lite slave memory BFM with programmable wait states and two-cycle ERROR.
// Define BFM_AHBL_SLAVE_RANDWAIT_EN to randomize the per-transfer wait count with a 16-bit LFSR.
module bfm_ahbl_slave_mem #(
   parameter int          AWIDTH   = 12,
   parameter int          TPD      = 1,
   parameter logic [31:0] ERR_BASE = 32'hFFFF_FFFF
) (
   input  logic        HCLK,
   input  logic        HRESETN,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic        HMASTLOCK,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADYIN,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   input  logic [3:0]  WAIT_CYCLES,
   output logic [15:0] ACCESS_CNT
);
   localparam int WW = AWIDTH - 2;
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
   logic [31:0] mem [2**WW];
   state_t state_q, state_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [1:0] size_q, size_d;
   logic write_q, write_d;
   logic [3:0] cnt_q, cnt_d, cnt_in;
   logic hready_q, hready_d, hresp_q, hresp_d;
   logic [31:0] hrdata_q, hrdata_d;
   logic [15:0] acnt_q, acnt_d;
   logic accept, legal, wr_now;
   logic [3:0] be;
   logic [31:0] merged, rd_val;
   logic [WW-1:0] rd_idx;
   logic unused_ok;
   assign unused_ok = &{1'b0, HBURST, HMASTLOCK, HPROT, HTRANS[0], HADDR[31:AWIDTH], TPD != 0};
   assign accept = HSEL & HREADYIN & HTRANS[1] & (state_q inside {S_IDLE, S_DATA, S_ERR2});
   assign legal = (HSIZE <= 3'd2) && !(HSIZE == 3'd1 && HADDR[0]) && !(HSIZE == 3'd2 && HADDR[1:0] != 2'd0)
                  && (32'(HADDR[AWIDTH-1:0]) < ERR_BASE);
   assign wr_now = (state_q == S_DATA) && write_q;
   assign be = size_q == 2'd2 ? 4'hF : size_q == 2'd1 ? (addr_q[1] ? 4'hC : 4'h3) : 4'b0001 << addr_q[1:0];
   always_comb begin
      merged = mem[addr_q[AWIDTH-1:2]];
      for (int i = 0; i < 4; i++)
         if (be[i]) merged[8*i +: 8] = HWDATA[8*i +: 8];
   end
   // a read accepted while a write closes to the same word sees the merged new data
   assign rd_idx = state_q == S_WAIT ? addr_q[AWIDTH-1:2] : HADDR[AWIDTH-1:2];
   assign rd_val = (wr_now && rd_idx == addr_q[AWIDTH-1:2]) ? merged : mem[rd_idx];
`ifdef BFM_AHBL_SLAVE_RANDWAIT_EN
   logic [15:0] lfsr_q, lfsr_d;
   assign lfsr_d = accept ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
   assign cnt_in = 4'(lfsr_q % (16'(WAIT_CYCLES) + 16'd1));
   always_ff @(posedge HCLK or negedge HRESETN)
      if (!HRESETN) lfsr_q <= 16'hACE1;
      else lfsr_q <= lfsr_d;
`else
   assign cnt_in = WAIT_CYCLES;
`endif
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      write_d  = write_q;
      cnt_d    = cnt_q;
      hready_d = 1'b1;
      hresp_d  = 1'b0;
      hrdata_d = '0;
      acnt_d   = acnt_q + 16'(state_q == S_DATA);
      if (state_q == S_WAIT) begin
         if (cnt_q == 4'd1) begin
            state_d  = S_DATA;
            hrdata_d = write_q ? '0 : rd_val;
         end else begin
            cnt_d    = cnt_q - 4'd1;
            hready_d = 1'b0;
         end
      end else if (state_q == S_ERR1) begin
         state_d = S_ERR2;
         hresp_d = 1'b1;
      end else if (accept) begin
         addr_d  = HADDR[AWIDTH-1:0];
         size_d  = HSIZE[1:0];
         write_d = HWRITE;
         if (!legal) begin
            state_d  = S_ERR1;
            hready_d = 1'b0;
            hresp_d  = 1'b1;
         end else if (cnt_in != 4'd0) begin
            state_d  = S_WAIT;
            cnt_d    = cnt_in;
            hready_d = 1'b0;
         end else begin
            state_d  = S_DATA;
            hrdata_d = HWRITE ? '0 : rd_val;
         end
      end else begin
         state_d = S_IDLE;
      end
   end
   always_ff @(posedge HCLK or negedge HRESETN)
      if (!HRESETN) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
         cnt_q    <= '0;
         hready_q <= 1'b1;
         hresp_q  <= 1'b0;
         hrdata_q <= '0;
         acnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         write_q  <= write_d;
         cnt_q    <= cnt_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
         hrdata_q <= hrdata_d;
         acnt_q   <= acnt_d;
      end
   always_ff @(posedge HCLK)
      if (wr_now) mem[addr_q[AWIDTH-1:2]] <= merged;
   assign HREADYOUT  = hready_q;
   assign HRESP      = hresp_q;
   assign HRDATA     = hrdata_q;
   assign ACCESS_CNT = acnt_q;
endmodule

// File: tb/tb_bfm_ahbl_slave_mem.sv
// tb_bfm_ahbl_slave_mem: randomized bench for bfm_ahbl_slave_mem against a byte-array memory model.
module tb_bfm_ahbl_slave_mem;
   logic        HCLK = 1'b0, HRESETN = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, HMASTLOCK = 1'b0;
   logic [31:0] HADDR = '0, HWDATA = '0;
   logic [1:0]  HTRANS = '0;
   logic [2:0]  HSIZE = '0, HBURST = '0;
   logic [3:0]  HPROT = '0, WAIT_CYCLES = '0;
   logic        HREADYIN, HREADYOUT, HRESP;
   logic [31:0] HRDATA;
   logic [15:0] ACCESS_CNT;
   int n_chk = 0, n_err = 0;
   logic [7:0] ref_mem [4096];
   int unsigned exp_cnt = 0;

   bfm_ahbl_slave_mem dut (
      .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
      .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .HRDATA(HRDATA), .WAIT_CYCLES(WAIT_CYCLES), .ACCESS_CNT(ACCESS_CNT)
   );

   assign HREADYIN = HREADYOUT;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int b = int'(a[11:2]) * 4;
      return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
   endfunction

   function automatic bit ref_legal(input logic [2:0] sz, input logic [31:0] a);
      if (sz > 3'd2) return 1'b0;
      return (int'(a[11:0]) % (1 << sz)) == 0;
   endfunction

   task automatic ref_write(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
      for (int i = 0; i < (1 << sz); i++) begin
         int b = int'(a[11:0]) + i;
         ref_mem[b] = wd[8*(b%4) +: 8];
      end
   endtask

   task automatic xfer(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] wc, output logic [31:0] rd, output logic r1, output logic r2,
                       output int waits);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HSIZE = sz; HADDR = a; WAIT_CYCLES = wc;
      @(posedge HCLK); #1;
      HTRANS = 2'b00; HWDATA = wd;
      waits = 0;
      @(negedge HCLK);
      r1 = HRESP;
      while (!HREADYOUT && waits < 40) begin
         waits++;
         @(negedge HCLK);
      end
      if (!HREADYOUT) check("timeout", 32'(HREADYOUT), 32'd1);
      rd = HRDATA;
      r2 = HRESP;
      @(posedge HCLK); #1;
   endtask

   task automatic do_check(input string tag, input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] wc);
      logic [31:0] rd, exp_rd;
      logic r1, r2;
      int wt;
      bit lg = ref_legal(sz, a);
      exp_rd = (lg && !w) ? ref_word(a) : 32'd0;
      xfer(w, sz, a, wd, wc, rd, r1, r2, wt);
      if (lg) begin
         exp_cnt++;
         if (w) ref_write(sz, a, wd);
      end
      check({tag, ":waits"}, 32'(wt), lg ? 32'(wc) : 32'd1);
      check({tag, ":resp1"}, 32'(r1), lg ? 32'd0 : 32'd1);
      check({tag, ":resp2"}, 32'(r2), lg ? 32'd0 : 32'd1);
      check({tag, ":rdata"}, rd, exp_rd);
      check({tag, ":cnt"}, 32'(ACCESS_CNT), 32'(exp_cnt[15:0]));
   endtask

   task automatic b2b(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] ra, exp;
      ra = {a[31:2], 2'b00};
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = sz; HADDR = a; WAIT_CYCLES = 4'd0;
      @(posedge HCLK); #1;
      HWRITE = 1'b0; HSIZE = 3'd2; HADDR = ra; HWDATA = wd;
      ref_write(sz, a, wd);
      exp = ref_word(ra);
      @(negedge HCLK);
      check("b2b_wr_ready", 32'(HREADYOUT), 32'd1);
      check("b2b_wr_rdata", HRDATA, 32'd0);
      @(posedge HCLK); #1;
      HTRANS = 2'b00;
      @(negedge HCLK);
      check("b2b_rd_ready", 32'(HREADYOUT), 32'd1);
      check("b2b_rd_rdata", HRDATA, exp);
      @(posedge HCLK); #1;
      exp_cnt += 2;
      check("b2b_cnt", 32'(ACCESS_CNT), 32'(exp_cnt[15:0]));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, a, old;
      logic r1, r2;
      logic [2:0] sz;
      int wt;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
      repeat (2) @(negedge HCLK);
      check("rst_ready", 32'(HREADYOUT), 32'd1);
      check("rst_resp", 32'(HRESP), 32'd0);
      check("rst_rdata", HRDATA, 32'd0);
      check("rst_cnt", 32'(ACCESS_CNT), 32'd0);
      HRESETN = 1'b1;
      @(posedge HCLK); #1;
      for (int i = 0; i < 64; i++) do_check("init", 1'b1, 3'd2, 32'(i * 4), $urandom, 4'd0);

      old = ref_word(32'h40);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h40; WAIT_CYCLES = 4'd5;
      @(posedge HCLK); #1;
      HTRANS = 2'b00; HWDATA = 32'hDEADBEEF;
      @(negedge HCLK); @(negedge HCLK);
      check("rstw_prewait", 32'(HREADYOUT), 32'd0);
      HRESETN = 1'b0; #1;
      check("rstw_ready", 32'(HREADYOUT), 32'd1);
      check("rstw_resp", 32'(HRESP), 32'd0);
      check("rstw_rdata", HRDATA, 32'd0);
      check("rstw_cnt", 32'(ACCESS_CNT), 32'd0);
      exp_cnt = 0;
      @(negedge HCLK);
      HRESETN = 1'b1;
      xfer(1'b0, 3'd2, 32'h40, 32'd0, 4'd0, rd, r1, r2, wt);
      exp_cnt++;
      check("rstw_old", rd, old);

      b2b(3'd2, 32'h10, 32'h12345678);
      check("b2b_const", ref_word(32'h10), 32'h12345678);

      do_check("bw_word", 1'b1, 3'd2, 32'h20, 32'h11223344, 4'd0);
      do_check("bw_b1", 1'b1, 3'd0, 32'h21, 32'hAAAAAAAA, 4'd0);
      do_check("bw_b2", 1'b1, 3'd0, 32'h22, 32'hBBBBBBBB, 4'd0);
      xfer(1'b0, 3'd2, 32'h20, 32'd0, 4'd0, rd, r1, r2, wt);
      exp_cnt++;
      check("bw_read", rd, 32'h11BBAA44);

      do_check("wait3", 1'b0, 3'd2, 32'h20, 32'd0, 4'd3);
      do_check("err_half", 1'b1, 3'd1, 32'h33, 32'hFFFFFFFF, 4'd0);
      do_check("err_size", 1'b1, 3'd3, 32'h30, 32'hFFFFFFFF, 4'd2);
      do_check("err_mem", 1'b0, 3'd2, 32'h30, 32'd0, 4'd0);

      HSEL = 1'b1;
      for (int i = 0; i < 10; i++) begin
         HTRANS = 2'($urandom_range(0, 1)); HADDR = 32'($urandom_range(0, 255)); HWRITE = 1'($urandom);
         @(negedge HCLK);
         check("idle_ready", 32'(HREADYOUT), 32'd1);
         check("idle_resp", 32'(HRESP), 32'd0);
         check("idle_rdata", HRDATA, 32'd0);
         @(posedge HCLK); #1;
      end
      HTRANS = 2'b00;
      check("idle_cnt", 32'(ACCESS_CNT), 32'(exp_cnt[15:0]));

      for (int i = 0; i < 300; i++) begin
         sz = $urandom_range(0, 7) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
         a = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~(32'((1 << sz) - 1));
         if ($urandom_range(0, 9) == 0 && sz <= 3'd2) b2b(sz, a & ~(32'((1 << sz) - 1)), $urandom);
         else do_check("rnd", 1'($urandom), sz, a, $urandom, 4'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
